// File: rtl/pulse_freq_counter_if.sv
// pulse_freq_counter_if: run control, raw pulse input and measurement result
// of the pulse frequency counter. The controller drives through master, the
// counter sits on slave.
interface pulse_freq_counter_if #(
    parameter int COUNT_WIDTH = 12
);
    logic                   enable;
    logic [2:0]             clk_config;
    logic                   input_pulse;
    logic [COUNT_WIDTH-1:0] edge_count;
    logic                   count_valid;
    logic                   overflow;

    modport master (
        output enable, clk_config, input_pulse,
        input  edge_count, count_valid, overflow
    );

    modport slave (
        input  enable, clk_config, input_pulse,
        output edge_count, count_valid, overflow
    );
endinterface

// File: rtl/pulse_freq_counter.sv
// pulse_freq_counter: counts rising edges of an asynchronous pulse over a gate
// window of 2^(BASE_SHIFT + clk_config) clock cycles and reports the count at
// the end of each window. One discarded window (SETTLE) precedes counting after
// enable or a clk_config change.
// Optional build macro PULSE_DEGLITCH_EN adds a 3-sample agreement filter after
// the synchronizer (rejects single-cycle glitches, edge latency 3 -> 5 clocks).
module pulse_freq_counter #(
    parameter int BASE_SHIFT  = 10,
    parameter int COUNT_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    pulse_freq_counter_if.slave bus
);
    // Widest window is 2^(BASE_SHIFT+7); the counter only needs to reach its last index.
    localparam int WIN_W = BASE_SHIFT + 7;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] COUNT  = 2'd2;

    logic [1:0]             sync_q;
    logic                   cond;
    logic                   cond_q;
    logic                   rise_det;

    logic [1:0]             state;
    logic [2:0]             cfg_q;
    logic [WIN_W-1:0]       win_cnt;
    logic [COUNT_WIDTH-1:0] acc;
    logic                   ovf_acc;

    logic [WIN_W-1:0]       win_last;
    logic                   win_end;
    logic                   acc_full;
    logic [COUNT_WIDTH-1:0] acc_next;
    logic                   ovf_next;

    logic [COUNT_WIDTH-1:0] edge_count_q;
    logic                   count_valid_q;
    logic                   overflow_q;

    // Synchronize the raw pulse and keep the previous conditioned value for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            cond_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values;
            // blocking ones here would collapse the two synchronizer stages into one.
            sync_q <= {sync_q[0], bus.input_pulse};
            cond_q <= cond;
        end
    end

`ifdef PULSE_DEGLITCH_EN
    logic [1:0] hist_q;

    // Two older synchronized samples; the filtered level only moves when all three agree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
        end
    end

    // cond_q doubles as the filter state, so the filter costs exactly two extra clocks.
    assign cond = ((sync_q[1] == hist_q[0]) && (sync_q[1] == hist_q[1])) ? sync_q[1] : cond_q;
`else
    assign cond = sync_q[1];
`endif

    assign rise_det = cond & ~cond_q;

    // Window terminal detection and saturating next value of the edge accumulator.
    always_comb begin
        // NOTE: every signal of this block is assigned on every pass through it,
        // so none can hold a previous value and no latch is inferred.
        win_last = {WIN_W{1'b1}} >> (3'd7 - cfg_q);
        win_end  = (win_cnt == win_last);
        acc_full = &acc;
        acc_next = acc_full ? acc : acc + COUNT_WIDTH'(rise_det);
        ovf_next = ovf_acc | (acc_full & rise_det);
    end

    // Run-control FSM, window counter, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cfg_q         <= '0;
            win_cnt       <= '0;
            acc           <= '0;
            ovf_acc       <= 1'b0;
            edge_count_q  <= '0;
            count_valid_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            cfg_q         <= bus.clk_config;
            count_valid_q <= 1'b0;
            if (!bus.enable) begin
                state   <= IDLE;
                win_cnt <= '0;
                acc     <= '0;
                ovf_acc <= 1'b0;
            end else if ((state != IDLE) && (bus.clk_config != cfg_q)) begin
                // New gate length: abandon the current window and settle again.
                state   <= SETTLE;
                win_cnt <= '0;
                acc     <= '0;
                ovf_acc <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= SETTLE;
                        win_cnt <= '0;
                        acc     <= '0;
                        ovf_acc <= 1'b0;
                    end
                    SETTLE: begin
                        if (win_end) begin
                            state   <= COUNT;
                            win_cnt <= '0;
                        end else begin
                            win_cnt <= win_cnt + WIN_W'(1);
                        end
                    end
                    COUNT: begin
                        if (win_end) begin
                            // The terminal-cycle edge goes into this result; the next
                            // window's first edge is added on the following clock.
                            edge_count_q  <= acc_next;
                            overflow_q    <= ovf_next;
                            count_valid_q <= 1'b1;
                            acc           <= '0;
                            ovf_acc       <= 1'b0;
                            win_cnt       <= '0;
                        end else begin
                            acc     <= acc_next;
                            ovf_acc <= ovf_next;
                            win_cnt <= win_cnt + WIN_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.edge_count  = edge_count_q;
    assign bus.count_valid = count_valid_q;
    assign bus.overflow    = overflow_q;
endmodule
